// File: rtl/add_seq_pkg.sv
// Shared constants for the nibble-serial adder: state encoding and default operand size.
// Imported by the interface, the controller and its testbench.
package add_seq_pkg;

   localparam int NIBBLES_DEFAULT = 4;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Slice index width; a single-nibble adder still needs one index bit.
   function automatic int idxWidth(input int nibbles);
      return (nibbles > 1) ? $clog2(nibbles) : 1;
   endfunction

endpackage

// File: rtl/add16_seq_ctrl_if.sv
// Request/result bundle of the nibble-serial adder.
// The requester drives the master side; the adder implements the slave side.
interface add16_seq_ctrl_if
   import add_seq_pkg::*;
#(
   parameter int NIBBLES = NIBBLES_DEFAULT
) ();

   localparam int W = 4 * NIBBLES;

   logic         START;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         C_IN;
   logic         BUSY;
   logic         DONE;
   logic [W-1:0] SUM;
   logic         C_OUT;
   logic         OVF;

   modport master (
      output START, A, B, C_IN,
      input  BUSY, DONE, SUM, C_OUT, OVF
   );

   modport slave (
      input  START, A, B, C_IN,
      output BUSY, DONE, SUM, C_OUT, OVF
   );

endinterface

// File: rtl/fulladd4_sar.sv
// 4-bit full adder slice; the only adder in the datapath, reused once per nibble.
module fulladd4_sar (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       c_i,
   output logic [3:0] sum_o,
   output logic       c_o
);

   assign {c_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, c_i};

endmodule

// File: rtl/add16_seq_ctrl.sv
// Nibble-serial adder controller: one 4-bit adder walks the operands LSB first,
// and the full result is published only when the last slice has been added.
module add16_seq_ctrl
   import add_seq_pkg::*;
#(
   parameter int NIBBLES = NIBBLES_DEFAULT
) (
   input logic              CLK,
   input logic              RST,
   add16_seq_ctrl_if.slave  bus
);

   localparam int                W        = 4 * NIBBLES;
   localparam int                IDX_W    = idxWidth(NIBBLES);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NIBBLES - 1);

   logic [1:0]       state_q, state_d;
   logic [W-1:0]     opA_q, opA_d;
   logic [W-1:0]     opB_q, opB_d;
   logic [W-1:0]     work_q, work_d;
   logic [W-1:0]     sum_q, sum_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             carry_q, carry_d;
   logic             cOut_q, cOut_d;
   logic             ovf_q, ovf_d;

   logic [IDX_W+1:0] bitBase;
   logic [3:0]       nibA;
   logic [3:0]       nibB;
   logic [3:0]       nibSum;
   logic             nibCo;

   assign bitBase = {idx_q, 2'b00};
   assign nibA    = opA_q[bitBase +: 4];
   assign nibB    = opB_q[bitBase +: 4];

   fulladd4_sar uAdder (
      .a_i   (nibA),
      .b_i   (nibB),
      .c_i   (carry_q),
      .sum_o (nibSum),
      .c_o   (nibCo)
   );

   // Next-state logic; the carry register is seeded with C_IN so slice 0 needs no special case.
   always_comb begin
      state_d = state_q;
      opA_d   = opA_q;
      opB_d   = opB_q;
      work_d  = work_q;
      sum_d   = sum_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      cOut_d  = cOut_q;
      ovf_d   = ovf_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.START) begin
               opA_d   = bus.A;
               opB_d   = bus.B;
               carry_d = bus.C_IN;
               idx_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            work_d[bitBase +: 4] = nibSum;
            carry_d              = nibCo;
            idx_d                = idx_q + IDX_W'(1);
            // The last slice publishes the freshly completed word on the same edge.
            if (idx_q == LAST_IDX) begin
               state_d = ST_DONE;
               sum_d   = work_d;
               cOut_d  = nibCo;
               ovf_d   = (opA_q[W-1] == opB_q[W-1]) && (work_d[W-1] != opA_q[W-1]);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers with synchronous reset that also aborts an operation in flight.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
         opA_q   <= '0;
         opB_q   <= '0;
         work_q  <= '0;
         sum_q   <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         cOut_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         opA_q   <= opA_d;
         opB_q   <= opB_d;
         work_q  <= work_d;
         sum_q   <= sum_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         cOut_q  <= cOut_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.BUSY  = (state_q == ST_RUN);
   assign bus.DONE  = (state_q == ST_DONE);
   assign bus.SUM   = sum_q;
   assign bus.C_OUT = cOut_q;
   assign bus.OVF   = ovf_q;

endmodule

// File: doc/add16_seq_ctrl.md
ADD16_SEQ_CTRL -- requirements
Module: add16_seq_ctrl

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, number of 4-bit slices per operand (operand width W = 4*NIBBLES).
REQ-002 SHALL have port CLK  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port START  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 SHALL have port A  input  W  operand A; captured on accepted START.
REQ-006 SHALL have port B  input  W  operand B; captured on accepted START.
REQ-007 SHALL have port C_IN  input  1  carry-in; captured on accepted START.
REQ-008 SHALL have port BUSY  output  1  high while in RUN.
REQ-009 SHALL have port DONE  output  1  one-cycle pulse; result valid.
REQ-010 SHALL have port SUM  output  W  result of A+B+C_IN, modulo 2^W.
REQ-011 SHALL have port C_OUT  output  1  carry out of bit W-1.
REQ-012 SHALL have port OVF  output  1  two's-complement overflow of the addition.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE.
REQ-014 SHALL, in IDLE with START=1 at an edge, latch A, B, C_IN into working registers, clear slice index to 0, and go to RUN.
REQ-015 SHALL, in IDLE with START=0, remain in IDLE.
REQ-016 SHALL, each RUN cycle, drive the single 4-bit adder with nibble[idx] of latched A and B and the carry register (C_IN for idx 0).
REQ-017 SHALL, at each RUN edge, write the adder sum into nibble[idx] of the working sum, load the adder carry-out into the carry register, and increment idx.
REQ-018 SHALL process nibbles LSB first; at the edge processing idx = NIBBLES-1 go to DONE.
REQ-019 SHALL, on entering DONE, transfer working sum to SUM, final carry to C_OUT, and OVF = (A[W-1]==B[W-1]) && (SUM[W-1]!=A[W-1]) using latched operands, all in the same edge.
REQ-020 SHALL assert DONE for exactly the one cycle spent in DONE, then return to IDLE unconditionally.
REQ-021 SHALL give latency: START sampled at edge n -> DONE high in the cycle after edge n+NIBBLES (4 cycles for default).
REQ-022 SHALL ignore START in RUN and DONE (no restart, no operand change); START must be re-presented in IDLE.
REQ-023 SHALL hold SUM, C_OUT, OVF stable from DONE until the next DONE; partial results are never visible on outputs.
REQ-024 SHALL keep BUSY=1 exactly in RUN, 0 in IDLE and DONE.
REQ-025 SHALL not depend on A, B, C_IN changing after capture.

Reset
REQ-026 SHALL, when RST=1 at an edge, go to IDLE and clear BUSY, DONE, SUM, C_OUT, OVF, idx, carry and working registers to 0.
REQ-027 SHALL let RST override START and abort any RUN/DONE in progress; no DONE pulse is produced for an aborted operation.
REQ-028 SHALL accept a START at the first edge after RST deasserts.

Structure
REQ-029 SHALL place the state encoding (IDLE=0, RUN=1, DONE=2, 2 bits) and the NIBBLES default in shared package add_seq_pkg.
REQ-030 SHALL instantiate exactly one existing fulladd4_sar as the shared datapath; no other adder logic for SUM.
REQ-031 SHALL size idx as clog2(NIBBLES) bits (minimum 1).

Verification
REQ-032 SHALL cover: A=0x0003, B=0x0004, C_IN=0 -> SUM=0x0007, C_OUT=0, OVF=0, DONE 4 cycles after START, BUSY high 4 cycles.
REQ-033 SHALL cover: A=0xFFFF, B=0x0001, C_IN=0 -> SUM=0x0000, C_OUT=1, OVF=0.
REQ-034 SHALL cover: A=0x7FFF, B=0x0001, C_IN=0 -> SUM=0x8000, C_OUT=0, OVF=1.
REQ-035 SHALL cover: A=0x0FFF, B=0x0000, C_IN=1 -> SUM=0x1000 (carry ripples through three nibbles), C_OUT=0.
REQ-036 SHALL cover: START with A=0x1234, B=0x1111, then START pulsed in RUN with A=0xFFFF, B=0xFFFF -> SUM=0x2345, single DONE.
REQ-037 SHALL cover: RST asserted during second RUN cycle -> next cycle IDLE, all outputs 0, no DONE; following START A=0x0009, B=0x0009 -> SUM=0x0012.
